// File: rtl/apb_timer.sv
// APB machine timer: free-running 64-bit mtime with prescaler, 64-bit compare, sticky pending flag
// and a level interrupt. Every APB access completes with exactly one wait state.
module apb_timer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rts,
  input  logic [ADDR_WIDTH-1:0] APB_paddr,
  input  logic [DATA_WIDTH-1:0] APB_pdata,
  output logic [DATA_WIDTH-1:0] APB_prdata,
  input  logic                  APB_psel,
  input  logic                  APB_penable,
  input  logic                  APB_pwrite,
  input  logic [3:0]            APB_pstb,
  output logic                  APB_pready,
  output logic                  APB_perr,
  output logic                  interrupt,
  output logic                  fsm_state
);

  // Handshake: an access is taken when psel & penable are seen in IDLE; pready, prdata and perr
  // are registered at that edge and held for exactly one cycle (ACK), then return to 0.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t state, state_next;
  logic   access;

  logic [63:0]               mtime, mtime_run, mtime_next;
  logic [63:0]               mtimecmp, mtimecmp_next;
  logic [31:0]               hi_shadow;
  logic                      ctrl_en, ctrl_ie, ctrl_periodic;
  logic                      ie_next, en_next, periodic_next;
  logic                      pending, pending_next;
  logic [PRESCALE_WIDTH-1:0] prescale, prescale_next;
  logic [PRESCALE_WIDTH-1:0] presc_cnt, presc_cnt_next;
  logic [2:0]                reg_sel;
  logic [7:0]                wr_sel;
  logic                      rd;
  logic [31:0]               rdata;
  logic                      match, tick, reload;
  logic                      unused;

  assign reg_sel   = APB_paddr[4:2];
  assign unused    = ^{APB_paddr[ADDR_WIDTH-1:5], APB_paddr[1:0]};
  assign fsm_state = (state == ACK);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [3:0] stb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (stb[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

  always_comb begin
    state_next = state;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (APB_psel && APB_penable && !APB_pready) begin
          access     = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_sel = '0;
    if (access && APB_pwrite) wr_sel[reg_sel] = 1'b1;
  end
  assign rd = access && !APB_pwrite;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0: rdata = mtime[31:0];
      3'd1: rdata = hi_shadow;
      3'd2: rdata = mtimecmp[31:0];
      3'd3: rdata = mtimecmp[63:32];
      3'd4: rdata = {29'b0, ctrl_periodic, ctrl_ie, ctrl_en};
      3'd5: rdata = {31'b0, pending};
      3'd6: rdata = 32'(prescale);
      default: rdata = '0;
    endcase
  end

  assign match  = (mtime >= mtimecmp);
  assign tick   = ctrl_en && (presc_cnt == prescale);
  assign reload = ctrl_en && ctrl_periodic && match;

  // Written bytes of mtime override the tick/reload result; unwritten bytes keep it.
  always_comb begin
    mtime_run  = reload ? 64'd0 : (tick ? mtime + 64'd1 : mtime);
    mtime_next = mtime_run;
    if (wr_sel[0]) mtime_next[31:0]  = merge(mtime_run[31:0], APB_pdata, APB_pstb);
    if (wr_sel[1]) mtime_next[63:32] = merge(mtime_run[63:32], APB_pdata, APB_pstb);
  end

  always_comb begin
    mtimecmp_next = mtimecmp;
    if (wr_sel[2]) mtimecmp_next[31:0]  = merge(mtimecmp[31:0], APB_pdata, APB_pstb);
    if (wr_sel[3]) mtimecmp_next[63:32] = merge(mtimecmp[63:32], APB_pdata, APB_pstb);
  end

  always_comb begin
    en_next       = ctrl_en;
    ie_next       = ctrl_ie;
    periodic_next = ctrl_periodic;
    if (wr_sel[4] && APB_pstb[0]) begin
      en_next       = APB_pdata[0];
      ie_next       = APB_pdata[1];
      periodic_next = APB_pdata[2];
    end
  end

  // A match in the same cycle as a W1C wins: pending stays set.
  assign pending_next = match || (pending && !(wr_sel[5] && APB_pstb[0] && APB_pdata[0]));

  always_comb begin
    prescale_next = prescale;
    if (wr_sel[6]) begin
      for (int i = 0; i < PRESCALE_WIDTH; i++) begin
        if (APB_pstb[i/8]) prescale_next[i] = APB_pdata[i];
      end
    end
  end

  always_comb begin
    presc_cnt_next = presc_cnt;
    if (wr_sel[6])            presc_cnt_next = '0;
    else if (reload || tick)  presc_cnt_next = '0;
    else if (ctrl_en)         presc_cnt_next = presc_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rts) begin
    if (rts) begin
      state         <= IDLE;
      mtime         <= '0;
      mtimecmp      <= '1;
      hi_shadow     <= '0;
      ctrl_en       <= 1'b0;
      ctrl_ie       <= 1'b0;
      ctrl_periodic <= 1'b0;
      pending       <= 1'b0;
      prescale      <= '0;
      presc_cnt     <= '0;
      interrupt     <= 1'b0;
      APB_pready    <= 1'b0;
      APB_prdata    <= '0;
      APB_perr      <= 1'b0;
    end else begin
      state         <= state_next;
      mtime         <= mtime_next;
      mtimecmp      <= mtimecmp_next;
      ctrl_en       <= en_next;
      ctrl_ie       <= ie_next;
      ctrl_periodic <= periodic_next;
      pending       <= pending_next;
      prescale      <= prescale_next;
      presc_cnt     <= presc_cnt_next;
      interrupt     <= pending_next && ie_next;
      APB_pready    <= access;
      APB_prdata    <= access ? rdata : '0;
      APB_perr      <= access && (reg_sel == 3'd7);
      if (rd && reg_sel == 3'd0) hi_shadow <= mtime[63:32];
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: register-map vector table plus hand-written sequences for
// counting, prescale, shadowed 64-bit reads, compare/interrupt, periodic mode and reset.
module tb_apb_timer;

  logic        clk = 1'b0;
  logic        rts = 1'b1;
  logic [31:0] paddr = '0;
  logic [31:0] pdata = '0;
  logic [31:0] prdata;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [3:0]  pstb = '0;
  logic        pready;
  logic        perr;
  logic        interrupt;
  logic        fsm_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc;
  logic [31:0] rd;
  logic        er;

  apb_timer dut (
    .clk        (clk),
    .rts        (rts),
    .APB_paddr  (paddr),
    .APB_pdata  (pdata),
    .APB_prdata (prdata),
    .APB_psel   (psel),
    .APB_penable(penable),
    .APB_pwrite (pwrite),
    .APB_pstb   (pstb),
    .APB_pready (pready),
    .APB_perr   (perr),
    .interrupt  (interrupt),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic do_reset();
    rts = 1'b1;
    repeat (2) @(posedge clk);
    #1 rts = 1'b0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // driver: setup cycle, access cycle, wait for pready (bounded)
  task automatic apb(input logic wr, input logic [2:0] idx, input logic [31:0] wdata,
                     input logic [3:0] stb, output logic [31:0] rdata, output logic err);
    int waits;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = {27'b0, idx, 2'b00}; pdata = wdata; pstb = stb;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 8) begin
      @(posedge clk); #1;
      waits++;
    end
    check("wait_states", 64'(waits), 64'd1);
    rdata = prdata;
    err = perr;
    last_cyc = cyc;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr32(input logic [2:0] idx, input logic [31:0] wdata);
    logic [31:0] d;
    logic e;
    apb(1'b1, idx, wdata, 4'hF, d, e);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  stb;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[24];

  initial begin
    int c0, k, first_k;
    logic [31:0] e32;

    vecs[0]  = '{1'b0, 3'd0, 32'h0, 4'h0, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 3'd1, 32'h0, 4'h0, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 3'd2, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{1'b0, 3'd3, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{1'b0, 3'd4, 32'h0, 4'h0, 32'h0000_0000, 1'b0};
    vecs[5]  = '{1'b0, 3'd5, 32'h0, 4'h0, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 3'd6, 32'h0, 4'h0, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b0, 3'd7, 32'h0, 4'h0, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 3'd2, 32'hAABB_CCDD, 4'b0010, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 3'd2, 32'h0, 4'h0, 32'hFFFF_CCFF, 1'b0};
    vecs[10] = '{1'b1, 3'd3, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 3'd3, 32'h0, 4'h0, 32'h1234_5678, 1'b0};
    vecs[12] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 3'd6, 32'h0, 4'h0, 32'h0000_FFFF, 1'b0};
    vecs[14] = '{1'b1, 3'd4, 32'hFFFF_FFF8, 4'hF, 32'h0, 1'b0};
    vecs[15] = '{1'b0, 3'd4, 32'h0, 4'h0, 32'h0000_0000, 1'b0};
    vecs[16] = '{1'b1, 3'd4, 32'h0000_000E, 4'hF, 32'h0, 1'b0};
    vecs[17] = '{1'b0, 3'd4, 32'h0, 4'h0, 32'h0000_0006, 1'b0};
    vecs[18] = '{1'b0, 3'd5, 32'h0, 4'h0, 32'h0000_0000, 1'b0};
    vecs[19] = '{1'b1, 3'd7, 32'h0000_1234, 4'hF, 32'h0, 1'b1};
    vecs[20] = '{1'b0, 3'd2, 32'h0, 4'h0, 32'hFFFF_CCFF, 1'b0};
    vecs[21] = '{1'b1, 3'd1, 32'h0000_77A5, 4'b0001, 32'h0, 1'b0};
    vecs[22] = '{1'b0, 3'd0, 32'h0, 4'h0, 32'h0000_0000, 1'b0};
    vecs[23] = '{1'b0, 3'd1, 32'h0, 4'h0, 32'h0000_00A5, 1'b0};

    // reset state of every output
    do_reset();
    @(negedge clk);
    check("rst_pready", 64'(pready), 64'd0);
    check("rst_prdata", 64'(prdata), 64'd0);
    check("rst_perr", 64'(perr), 64'd0);
    check("rst_irq", 64'(interrupt), 64'd0);
    check("rst_state", 64'(fsm_state), 64'd0);

    // register map table
    for (int i = 0; i < 24; i++) begin
      apb(vecs[i].wr, vecs[i].idx, vecs[i].wdata, vecs[i].stb, rd, er);
      check($sformatf("vec%0d_perr", i), 64'(er), 64'(vecs[i].exp_err));
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp));
    end
    @(posedge clk); #1;
    check("pready_one_cycle", 64'(pready), 64'd0);

    // setup only, then psel dropped during the wait state: nothing commits
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pdata = 32'h0; pstb = 4'hF;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    k = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (pready) k++;
    end
    penable = 1'b0; pwrite = 1'b0;
    check("psel_drop_pready", 64'(k), 64'd0);
    apb(1'b0, 3'd2, 32'h0, 4'h0, rd, er);
    check("psel_drop_nocommit", 64'(rd), 64'hFFFF_CCFF);

    // reset during the wait state
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pdata = 32'h0; pstb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rts = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_pready", 64'(pready), 64'd0);
    rts = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb(1'b0, 3'd3, 32'h0, 4'h0, rd, er);
    check("rst_wait_nowrite", 64'(rd), 64'hFFFF_FFFF);

    // reset while pready is high: pready drops without waiting for a clock
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h8;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("ack_pready", 64'(pready), 64'd1);
    check("ack_state", 64'(fsm_state), 64'd1);
    rts = 1'b1;
    #1;
    check("async_rst_pready", 64'(pready), 64'd0);
    check("async_rst_state", 64'(fsm_state), 64'd0);
    @(posedge clk); #1;
    rts = 1'b0; psel = 1'b0; penable = 1'b0;

    // prescale 3: mtime advances once every 4 cycles after enable
    do_reset();
    wr32(3'd6, 32'd3);
    wr32(3'd4, 32'd1);
    c0 = last_cyc;
    repeat (38) @(posedge clk);
    #1;
    apb(1'b0, 3'd0, 32'h0, 4'h0, rd, er);
    check("presc_mtime", 64'(rd), 64'((last_cyc - 1 - c0) / 4));
    check("presc_mtime_10", 64'(rd), 64'd10);

    // coherent 64-bit read across the low-word carry
    do_reset();
    wr32(3'd0, 32'hFFFF_FFFF);
    apb(1'b0, 3'd0, 32'h0, 4'h0, rd, er);
    check("lo_before_carry", 64'(rd), 64'hFFFF_FFFF);
    wr32(3'd4, 32'd1);
    c0 = last_cyc;
    repeat (3) @(posedge clk);
    #1;
    apb(1'b0, 3'd1, 32'h0, 4'h0, rd, er);
    check("hi_shadow_old", 64'(rd), 64'd0);
    apb(1'b0, 3'd0, 32'h0, 4'h0, rd, er);
    e32 = 32'hFFFF_FFFF + 32'(last_cyc - 1 - c0);
    check("lo_after_carry", 64'(rd), 64'(e32));
    apb(1'b0, 3'd1, 32'h0, 4'h0, rd, er);
    check("hi_after_carry", 64'(rd), 64'd1);

    // compare at 20 with interrupt enabled
    do_reset();
    wr32(3'd2, 32'd20);
    wr32(3'd3, 32'd0);
    wr32(3'd4, 32'd3);
    c0 = last_cyc;
    check("irq_before", 64'(interrupt), 64'd0);
    first_k = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (interrupt && first_k < 0) first_k = cyc - c0;
    end
    check("irq_latency", 64'(first_k), 64'd21);
    wr32(3'd5, 32'd1);
    apb(1'b0, 3'd5, 32'h0, 4'h0, rd, er);
    check("w1c_during_match", 64'(rd), 64'd1);
    wr32(3'd3, 32'hFFFF_FFFF);
    check("pending_sticky_irq", 64'(interrupt), 64'd1);
    wr32(3'd5, 32'd1);
    check("irq_cleared", 64'(interrupt), 64'd0);
    apb(1'b0, 3'd5, 32'h0, 4'h0, rd, er);
    check("status_cleared", 64'(rd), 64'd0);

    // periodic mode: mtime cycles 0..5
    do_reset();
    wr32(3'd2, 32'd5);
    wr32(3'd3, 32'd0);
    wr32(3'd4, 32'd7);
    c0 = last_cyc;
    for (int d = 0; d < 6; d++) begin
      repeat (d) @(posedge clk);
      #1;
      apb(1'b0, 3'd0, 32'h0, 4'h0, rd, er);
      check($sformatf("periodic_mtime%0d", d), 64'(rd), 64'((last_cyc - 1 - c0) % 6));
    end
    apb(1'b0, 3'd5, 32'h0, 4'h0, rd, er);
    check("periodic_pending", 64'(rd), 64'd1);
    check("periodic_irq", 64'(interrupt), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
